// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

    // Smallest divisor that still produces a toggling output.
    localparam int DIV_MIN = 2;

    // Length of the high phase for a period of d cycles; odd d gets the extra cycle high.
    // Evaluated in 32 bits so the largest DIV_W-bit divisor never overflows.
    function automatic logic [31:0] hi_len(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

    // True when a reset divisor is usable for a given counter width.
    function automatic bit def_div_ok(input int def_div, input int div_w);
        return (def_div >= DIV_MIN) && (def_div <= (1 << div_w) - 1);
    endfunction

endpackage

// File: rtl/pow2_tap_counter.sv
// Free-running binary counter whose bits are the legacy power-of-two divided outputs.
module pow2_tap_counter #(
    parameter int NUM_TAPS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [NUM_TAPS-1:0] taps
);

    logic [NUM_TAPS-1:0] r_tap_cnt;

    // Count enabled cycles; bit i toggles every 2^i enabled cycles, dividing by 2^(i+1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tap_cnt <= '0;
        end else if (en) begin
            r_tap_cnt <= r_tap_cnt + NUM_TAPS'(1);
        end
    end

    assign taps = r_tap_cnt;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider with glitch-free ratio changes at period boundaries.
//
// Load handshake: div_load is a single-cycle strobe qualifying div_val; there is no
// ready, every strobe is consumed on the cycle it is seen. Values >= DIV_MIN are
// parked in the pending register and applied on the next enabled wrap; smaller
// values are dropped and flagged by a one-cycle load_err pulse.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int DEF_DIV  = 2,
    parameter int NUM_TAPS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DIV_W-1:0]    div_val,
    input  logic                div_load,
    output logic                clk_out,
    output logic                tick,
    output logic                load_pend,
    output logic                load_err,
    output logic [NUM_TAPS-1:0] taps
);

    // Elaboration-time guard on the parameter set.
    if (!def_div_ok(DEF_DIV, DIV_W) || DIV_W > 30) begin : g_bad_params
        $error("prog_clock_divider: DEF_DIV must be 2..2^DIV_W-1 and DIV_W <= 30");
    end

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] r_pend_q;
    logic             r_load_pend;
    logic             r_load_err;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_wrap;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_div_next;
    logic             w_clk_next;
    logic             w_load_ok;

    // Next-period arithmetic; a wrap with a pending value switches to the new divisor,
    // and the high-phase test uses the divisor of the period cnt_next belongs to.
    always_comb begin
        w_wrap     = (r_cnt == r_div_q - DIV_W'(1));
        w_cnt_next = w_wrap ? '0 : r_cnt + DIV_W'(1);
        w_div_next = (w_wrap && r_load_pend) ? r_pend_q : r_div_q;
        w_clk_next = (32'(w_cnt_next) < hi_len(32'(w_div_next)));
        w_load_ok  = (div_val >= DIV_W'(DIV_MIN));
    end

    // Period counter, divisor, pending load and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= DIV_W'(DEF_DIV - 1);
            r_div_q     <= DIV_W'(DEF_DIV);
            r_pend_q    <= '0;
            r_load_pend <= 1'b0;
            r_load_err  <= 1'b0;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            r_tick     <= 1'b0;
            if (en) begin
                r_cnt     <= w_cnt_next;
                r_div_q   <= w_div_next;
                r_clk_out <= w_clk_next;
                r_tick    <= (w_cnt_next == '0);
                if (w_wrap) begin
                    r_load_pend <= 1'b0;
                end
            end
            // A load on a wrap cycle overrides the clear above, so it waits for the next wrap.
            if (div_load) begin
                if (w_load_ok) begin
                    r_pend_q    <= div_val;
                    r_load_pend <= 1'b1;
                end else begin
                    r_load_err  <= 1'b1;
                end
            end
        end
    end

    pow2_tap_counter #(
        .NUM_TAPS (NUM_TAPS)
    ) u_taps (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .taps (taps)
    );

    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign load_pend = r_load_pend;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: vector table plus hand-written corner sequences.
module tb_prog_clock_divider;

    localparam int DIV_W    = 8;
    localparam int NUM_TAPS = 5;

    logic                clk;
    logic                rst;
    logic                en;
    logic [DIV_W-1:0]    div_val;
    logic                div_load;
    logic                clk_out;
    logic                tick;
    logic                load_pend;
    logic                load_err;
    logic [NUM_TAPS-1:0] taps;

    int n_checks;
    int n_fail;
    int n_en;

    typedef struct {
        logic             en;
        logic             ld;
        logic [DIV_W-1:0] val;
        logic             e_clk;
        logic             e_tick;
        logic             e_pend;
        logic             e_err;
    } vec_t;

    vec_t vecs[$];

    prog_clock_divider #(
        .DIV_W    (DIV_W),
        .DEF_DIV  (2),
        .NUM_TAPS (NUM_TAPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick      (tick),
        .load_pend (load_pend),
        .load_err  (load_err),
        .taps      (taps)
    );

    // clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; the tap model counts enabled edges. Sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst && en) n_en++;
        #1;
        div_load = 1'b0;
    endtask

    task automatic add(input logic e, input logic l, input int v,
                       input logic c, input logic t, input logic p, input logic r);
        vec_t x;
        x.en = e; x.ld = l; x.val = DIV_W'(v);
        x.e_clk = c; x.e_tick = t; x.e_pend = p; x.e_err = r;
        vecs.push_back(x);
    endtask

    task automatic chk_taps();
        logic [31:0] m;
        m = 32'(n_en) & 32'h1f;
        chk("taps", 32'(taps), m);
    endtask

    initial begin
        int hi;
        int tk;
        int got;
        n_checks = 0; n_fail = 0; n_en = 0;
        rst = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pend", 32'(load_pend), 0);
        chk("rst_err", 32'(load_err), 0);
        chk("rst_taps", 32'(taps), 0);
        rst = 1'b1;

        // divide by 2
        for (int i = 0; i < 4; i++) begin
            add(1, 0, 0, 1, 1, 0, 0);
            add(1, 0, 0, 0, 0, 0, 0);
        end
        // load 5 mid-period: 3 high / 2 low
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 1, 5, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        // load 7 then 4: latest wins
        add(1, 1, 7, 1, 0, 1, 0);
        add(1, 1, 4, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        // rejected loads 0 and 1
        add(1, 1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // load 3 on a wrap cycle: waits a full period
        add(1, 1, 3, 1, 1, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        // reload the current divisor: still pends
        add(1, 1, 3, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 0);
        // freeze 10 cycles in the high phase, load 6 while frozen
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 6, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            en = vecs[i].en;
            div_load = vecs[i].ld;
            div_val = vecs[i].val;
            step();
            chk($sformatf("v%0d_clk_out", i), 32'(clk_out), 32'(vecs[i].e_clk));
            chk($sformatf("v%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
            chk($sformatf("v%0d_pend", i), 32'(load_pend), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d_err", i), 32'(load_err), 32'(vecs[i].e_err));
            chk_taps();
        end

        // divide by 255: 128 high / 127 low
        en = 1'b1;
        div_load = 1'b1; div_val = 8'd255;
        step();
        chk("d255_pend_set", 32'(load_pend), 1);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (tick) begin
                got = 1;
                break;
            end
            step();
        end
        chk("d255_wrap_seen", 32'(got), 1);
        chk("d255_pend_clr", 32'(load_pend), 0);
        hi = clk_out ? 1 : 0;
        tk = 0;
        for (int k = 1; k < 255; k++) begin
            step();
            if (clk_out) hi++;
            if (tick) tk++;
            if (k == 127) chk("d255_last_high", 32'(clk_out), 1);
            if (k == 128) chk("d255_first_low", 32'(clk_out), 0);
        end
        chk("d255_high_cycles", 32'(hi), 128);
        chk("d255_ticks_inside", 32'(tk), 0);
        step();
        chk("d255_next_tick", 32'(tick), 1);
        chk_taps();

        // asynchronous reset mid-period discards a pending load
        div_load = 1'b1; div_val = 8'd9;
        step();
        chk("pre_rst_pend", 32'(load_pend), 1);
        #2 rst = 1'b0;
        #1;
        n_en = 0;
        chk("async_rst_clk_out", 32'(clk_out), 0);
        chk("async_rst_tick", 32'(tick), 0);
        chk("async_rst_pend", 32'(load_pend), 0);
        chk("async_rst_taps", 32'(taps), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("post_rst%0d_clk_out", k), 32'(clk_out), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("post_rst%0d_tick", k), 32'(tick), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("post_rst%0d_pend", k), 32'(load_pend), 0);
            chk_taps();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
